// File: rtl/alu_pkg.sv
// Opcode constants and FSM state encoding shared by the ALU arbiter.
// Opcodes 0..10 are legal; anything above OP_MAX_LEGAL is rejected.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_NAND = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_XNOR = 4'b0101;
  localparam logic [3:0] OP_SHL  = 4'b0110;
  localparam logic [3:0] OP_SHR  = 4'b0111;
  localparam logic [3:0] OP_ADD  = 4'b1000;
  localparam logic [3:0] OP_SUB  = 4'b1001;
  localparam logic [3:0] OP_DIV  = 4'b1010;

  localparam logic [3:0] OP_MAX_LEGAL = OP_DIV;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side bundle of the ALU arbiter: request handshake + response.
// master = requesters, slave = arbiter.
interface alu_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 16,
  parameter int OP_W    = 4
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*OP_W-1:0]   req_op;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_zero;
  logic                      rsp_error;

  modport master (
    output req_valid, req_op, req_a, req_b,
    input  req_ready, rsp_valid,
    input  rsp_data, rsp_zero, rsp_error
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    output req_ready, rsp_valid,
    output rsp_data, rsp_zero, rsp_error
  );

endinterface

// File: rtl/alu_arb_pick.sv
// Combinational one-hot picker: first set bit of req searching upward
// from start (wrapping). Ports: req, start -> grant (one-hot), idx.
module alu_arb_pick #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] start,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] idx
);

  always_comb begin
    int   pos;
    logic found;
    pos   = 0;
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      pos = (int'(start) + i) % N;
      if (!found && req[pos]) begin
        grant[pos] = 1'b1;
        idx        = PTR_W'(pos);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters: pick, latch,
// execute, respond (IDLE->EXEC->RESP). Ports: clk, rst (sync, high),
// bus (alu_arbiter_if.slave), busy, alu_operation/op1/op2 to ALU,
// alu_res/zero/error from ALU. Define ALU_ARB_RR_EN for round-robin;
// otherwise fixed priority, lowest index wins.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 16,
  parameter int OP_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  alu_arbiter_if.slave      bus,
  output logic              busy,
  output logic [OP_W-1:0]   alu_operation,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              alu_zero,
  input  logic              alu_error
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e state_q, state_d;

  logic [NUM_REQ-1:0] pick;
  logic [PTR_W-1:0]   pick_idx;
  logic [PTR_W-1:0]   start;
  logic               hs;

  logic [NUM_REQ-1:0] grant_q;
  logic [DATA_W-1:0]  data_q;
  logic               zero_q;
  logic               err_q;

  logic [OP_W-1:0]    sel_op;
  logic [DATA_W-1:0]  sel_a;
  logic [DATA_W-1:0]  sel_b;
  logic               bad_op;

  alu_arb_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req   (bus.req_valid),
    .start (start),
    .grant (pick),
    .idx   (pick_idx)
  );

`ifdef ALU_ARB_RR_EN
  logic [PTR_W-1:0] rr_q;

  assign start = rr_q;

  // Pointer moves past the winner, only when a transfer happens.
  always_ff @(posedge clk) begin
    if (rst)
      rr_q <= '0;
    else if (hs)
      rr_q <= (pick_idx == PTR_W'(NUM_REQ - 1))
            ? '0 : pick_idx + 1'b1;
  end
`else
  logic unused_idx;

  assign start      = '0;
  assign unused_idx = ^pick_idx;
`endif

  assign hs = (state_q == ST_IDLE) && (|pick);

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    busy          = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        bus.req_ready = pick;
        if (hs)
          state_d = ST_EXEC;
      end
      ST_EXEC: begin
        busy    = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        busy          = 1'b1;
        bus.rsp_valid = grant_q;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) begin
        sel_op = bus.req_op[i*OP_W +: OP_W];
        sel_a  = bus.req_a[i*DATA_W +: DATA_W];
        sel_b  = bus.req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  // Divide-by-zero and out-of-range opcodes are trapped here so the
  // response never depends on what the ALU does with them.
  assign bad_op =
    ((alu_operation == OP_W'(OP_DIV)) && (alu_op2 == '0)) ||
    (alu_operation > OP_W'(OP_MAX_LEGAL));

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_operation <= '0;
      alu_op1       <= '0;
      alu_op2       <= '0;
      grant_q       <= '0;
      data_q        <= '0;
      zero_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      if (hs) begin
        alu_operation <= sel_op;
        alu_op1       <= sel_a;
        alu_op2       <= sel_b;
        grant_q       <= pick;
      end
      if (state_q == ST_EXEC) begin
        if (bad_op) begin
          data_q <= '0;
          zero_q <= 1'b0;
          err_q  <= 1'b1;
        end else begin
          data_q <= alu_res;
          zero_q <= alu_zero;
          err_q  <= alu_error;
        end
      end
    end
  end

  assign bus.rsp_data  = data_q;
  assign bus.rsp_zero  = zero_q;
  assign bus.rsp_error = err_q;

endmodule
